out_port_ctrl: RTL and testbench

- Sequences writes from the CPU's memory-mapped output store path into the 32-bit output register.
- Buffers up to DEPTH pending values in a FIFO and issues one load strobe plus data per value.
- Enforces a minimum display time of HOLD_CYCLES between consecutive loads, so every value stays visible on the board display.
- Sits between the store-decode logic and the output register's load/data_in inputs.

---
 rtl/out_port_ctrl.sv | 111 +++++++++++
 tb/tb_out_port_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/out_port_ctrl.sv
// Output-port sequencer: buffers CPU store values in a small FIFO and
// issues them to the output register no closer than HOLD_CYCLES apart.
module out_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic                       out_load,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [1:0]            state;
    logic                  push;
    logic                  pop;

    // Ready looks only at the current fill level; a same-edge pop never frees a slot.
    always_comb wr_ready = !reset && !flush && (count < FULL_CNT);
    always_comb push     = wr_valid && wr_ready;

    always_comb begin
        if (hold_cnt != '0) begin
            state = ST_HOLD;
        end else if (count != '0) begin
            state = ST_ISSUE;
        end else begin
            state = ST_IDLE;
        end
    end

    always_comb pop     = (state == ST_ISSUE);
    always_comb pending = count;
    always_comb busy    = (count != '0) || (hold_cnt != '0);

    // Storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= '0;
            out_load <= 1'b0;
            out_data <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= '0;
            out_load <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case (state)
                ST_ISSUE: begin
                    out_load <= 1'b1;
                    out_data <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    hold_cnt <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    out_load <= 1'b0;
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                ST_IDLE: begin
                    out_load <= 1'b0;
                end
                default: begin
                    out_load <= 1'b0;
                end
            endcase

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: a HOLD_CYCLES=8 and a HOLD_CYCLES=1 instance driven
// in parallel, compared every cycle against a queue/timestamp reference model.
module tb_out_port_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          wr_ready8, out_load8, busy8;
    logic [DW-1:0] out_data8;
    logic [2:0]    pending8;
    logic          wr_ready1, out_load1, busy1;
    logic [DW-1:0] out_data1;
    logic [2:0]    pending1;

    always #5 clk = ~clk;

    out_port_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(8)) dut8 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready8), .flush(flush), .out_load(out_load8),
        .out_data(out_data8), .pending(pending8), .busy(busy8)
    );

    out_port_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready1), .flush(flush), .out_load(out_load1),
        .out_data(out_data1), .pending(pending1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending values as queues, hold window as issue timestamps.
    logic [DW-1:0] q8[$];
    logic [DW-1:0] q1[$];
    int            last_issue [2] = '{-1000, -1000};
    logic          exp_load   [2] = '{1'b0, 1'b0};
    logic [DW-1:0] exp_data   [2] = '{32'd0, 32'd0};
    logic          exp_ready  [2] = '{1'b0, 1'b0};
    logic          exp_busy   [2] = '{1'b0, 1'b0};
    int            edge_n = 0;
    logic          acc8;

    function automatic int hold_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q8.size() : q1.size();
    endfunction

    function automatic logic [DW-1:0] qpop(input int k);
        if (k == 0) return q8.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int k, input logic [DW-1:0] d);
        if (k == 0) q8.push_back(d);
        else q1.push_back(d);
    endfunction

    function automatic void qclear(input int k);
        if (k == 0) q8.delete();
        else q1.delete();
    endfunction

    function automatic void model_step(input int k, input logic r, input logic f,
                                       input logic v, input logic [DW-1:0] d);
        bit accept;
        if (r) begin
            qclear(k);
            last_issue[k] = -1000;
            exp_load[k]   = 1'b0;
            exp_data[k]   = '0;
        end else if (f) begin
            qclear(k);
            last_issue[k] = -1000;
            exp_load[k]   = 1'b0;
        end else begin
            accept = v && exp_ready[k];
            if (qsize(k) != 0 && (edge_n - last_issue[k]) >= hold_of(k)) begin
                exp_load[k]   = 1'b1;
                exp_data[k]   = qpop(k);
                last_issue[k] = edge_n;
            end else begin
                exp_load[k] = 1'b0;
            end
            if (accept) qpush(k, d);
        end
        exp_busy[k] = (qsize(k) != 0) || ((edge_n - last_issue[k]) < hold_of(k) - 1);
    endfunction

    task automatic cycle(input logic r, input logic f, input logic v, input logic [DW-1:0] d);
        reset = r; flush = f; wr_valid = v; wr_data = d;
        #1;
        for (int k = 0; k < 2; k++)
            exp_ready[k] = !r && !f && (qsize(k) < DEPTH);
        chk("wr_ready8", {31'd0, wr_ready8}, {31'd0, exp_ready[0]});
        chk("wr_ready1", {31'd0, wr_ready1}, {31'd0, exp_ready[1]});
        acc8 = v && wr_ready8;
        @(posedge clk);
        edge_n++;
        model_step(0, r, f, v, d);
        model_step(1, r, f, v, d);
        @(negedge clk);
        chk("out_load8", {31'd0, out_load8}, {31'd0, exp_load[0]});
        chk("out_data8", out_data8, exp_data[0]);
        chk("pending8",  {29'd0, pending8}, DW'(q8.size()));
        chk("busy8",     {31'd0, busy8}, {31'd0, exp_busy[0]});
        chk("out_load1", {31'd0, out_load1}, {31'd0, exp_load[1]});
        chk("out_data1", out_data1, exp_data[1]);
        chk("pending1",  {29'd0, pending1}, DW'(q1.size()));
        chk("busy1",     {31'd0, busy1}, {31'd0, exp_busy[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // Holds one value valid until the HOLD_CYCLES=8 instance accepts it.
    task automatic send8(input logic [DW-1:0] d);
        int n = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b1, d);
            n++;
        end while (!acc8 && n < 100);
        chk("send8_accept", {31'd0, acc8}, 32'd1);
    endtask

    initial begin
        // Reset, then a single write.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_00AB);
        idle(12);

        // Burst of four on consecutive edges.
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, DW'(i));
        idle(40);

        // Fill to DEPTH during hold, fifth value held valid until accepted.
        for (int i = 0; i < 5; i++) send8(32'h10 + DW'(i));
        idle(60);

        // Flush with three pending during hold, plus a write in the flush cycle.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h20 + DW'(i));
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_DEAD);
        idle(20);

        // Back-to-back writes; the HOLD_CYCLES=1 instance pops on every edge.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, DW'(i));
        idle(50);

        // Reset mid-hold with data pending, then normal latency afterwards.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'h30 + DW'(i));
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_BEEF);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0055);
        idle(12);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < 55, $urandom);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
